// File: rtl/pipe_hazard_ctrl.sv
// ID-stage scoreboard hazard controller: tracks in-flight destinations, raises the
// stall interlock or selects a forwarding stage for rs/rt, and guards HI/LO while the MDU is busy.
module pipe_hazard_ctrl #(
  parameter int NSTAGE     = 3,
  parameter int FWD_EN     = 0,
  parameter int ALU_READY  = 1,
  parameter int LOAD_READY = 2,
  parameter int MDU_LAT    = 4,
  parameter int REG_AW     = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic [REG_AW-1:0]             id_rs_addr,
  input  logic                          id_rs_used,
  input  logic [REG_AW-1:0]             id_rt_addr,
  input  logic                          id_rt_used,
  input  logic                          id_wr_en,
  input  logic [REG_AW-1:0]             id_wr_addr,
  input  logic                          id_is_load,
  input  logic                          id_is_mdu,
  input  logic                          id_reads_hilo,
  input  logic                          flush,
  output logic                          stall_out,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_rs_sel,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_rt_sel,
  output logic                          mdu_busy
);

  localparam int FSW = $clog2(NSTAGE+1);
  localparam int CW  = (MDU_LAT > 0) ? $clog2(MDU_LAT+1) : 1;

  logic [NSTAGE:1]             sb_vld_q, sb_vld_d;
  logic [NSTAGE:1]             sb_ld_q, sb_ld_d;
  logic [NSTAGE:1][REG_AW-1:0] sb_addr_q, sb_addr_d;
  logic [CW-1:0]               mdu_cnt_q, mdu_cnt_d;
  logic                        accept;
  logic                        rs_haz, rt_haz, mdu_haz;

  // Youngest matching producer decides; a match at write-back reads through the regfile.
  function automatic logic [FSW:0] src_check(
    input logic                          used,
    input logic [REG_AW-1:0]             addr,
    input logic [NSTAGE:1]               vld,
    input logic [NSTAGE:1]               ld,
    input logic [NSTAGE:1][REG_AW-1:0]   addrs
  );
    int             hit_k;
    logic           hit_ld;
    logic           haz;
    logic [FSW-1:0] sel;
    hit_k  = 0;
    hit_ld = 1'b0;
    haz    = 1'b0;
    sel    = '0;
    for (int k = NSTAGE; k >= 1; k--) begin
      if (vld[k] && (addrs[k] == addr)) begin
        hit_k  = k;
        hit_ld = ld[k];
      end
    end
    if (used && (addr != '0) && (hit_k != 0) && (hit_k < NSTAGE)) begin
      if (FWD_EN == 0)
        haz = 1'b1;
      else if (hit_k >= (hit_ld ? LOAD_READY : ALU_READY))
        sel = FSW'(hit_k);
      else
        haz = 1'b1;
    end
    return {haz, sel};
  endfunction

  assign {rs_haz, fwd_rs_sel} = src_check(id_rs_used, id_rs_addr, sb_vld_q, sb_ld_q, sb_addr_q);
  assign {rt_haz, fwd_rt_sel} = src_check(id_rt_used, id_rt_addr, sb_vld_q, sb_ld_q, sb_addr_q);

  assign mdu_busy  = (mdu_cnt_q != '0);
  assign mdu_haz   = (id_reads_hilo | id_is_mdu) & mdu_busy;
  assign stall_out = id_valid & ~flush & (rs_haz | rt_haz | mdu_haz);
  assign accept    = id_valid & ~stall_out & ~flush;

  always_comb begin
    sb_vld_d  = sb_vld_q;
    sb_ld_d   = sb_ld_q;
    sb_addr_d = sb_addr_q;
    for (int k = NSTAGE; k >= 2; k--) begin
      sb_vld_d[k]  = sb_vld_q[k-1];
      sb_ld_d[k]   = sb_ld_q[k-1];
      sb_addr_d[k] = sb_addr_q[k-1];
    end
    // Writes to $0 are never tracked, so they can never cause a hazard.
    sb_vld_d[1]  = accept & id_wr_en & (id_wr_addr != '0);
    sb_ld_d[1]   = id_is_load;
    sb_addr_d[1] = id_wr_addr;
  end

  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (MDU_LAT == 0)
      mdu_cnt_d = '0;
    else if (accept & id_is_mdu)
      mdu_cnt_d = CW'(MDU_LAT);
    else if (mdu_cnt_q != '0)
      mdu_cnt_d = mdu_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_vld_q  <= '0;
      mdu_cnt_q <= '0;
    end else begin
      sb_vld_q  <= sb_vld_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    sb_ld_q   <= sb_ld_d;
    sb_addr_q <= sb_addr_d;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: an interlock-only and a forwarding instance share one
// stimulus stream; each is checked every cycle against its own history-based model.
module tb_pipe_hazard_ctrl;

  localparam int NST  = 3;
  localparam int ARDY = 1;
  localparam int LRDY = 2;
  localparam int MLAT = 4;
  localparam int AW   = 5;
  localparam int FSW  = $clog2(NST+1);

  logic          clk, reset;
  logic          id_valid, id_rs_used, id_rt_used, id_wr_en;
  logic [AW-1:0] id_rs_addr, id_rt_addr, id_wr_addr;
  logic          id_is_load, id_is_mdu, id_reads_hilo, flush;
  logic          st0, st1, busy0, busy1;
  logic [FSW-1:0] rs0, rt0, rs1, rt1;

  pipe_hazard_ctrl #(.NSTAGE(NST), .FWD_EN(0), .ALU_READY(ARDY), .LOAD_READY(LRDY),
                     .MDU_LAT(MLAT), .REG_AW(AW)) u_stall (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
    .id_is_mdu(id_is_mdu), .id_reads_hilo(id_reads_hilo), .flush(flush),
    .stall_out(st0), .fwd_rs_sel(rs0), .fwd_rt_sel(rt0), .mdu_busy(busy0));

  pipe_hazard_ctrl #(.NSTAGE(NST), .FWD_EN(1), .ALU_READY(ARDY), .LOAD_READY(LRDY),
                     .MDU_LAT(MLAT), .REG_AW(AW)) u_fwd (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rt_addr(id_rt_addr), .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
    .id_is_mdu(id_is_mdu), .id_reads_hilo(id_reads_hilo), .flush(flush),
    .stall_out(st1), .fwd_rs_sel(rs1), .fwd_rt_sel(rt1), .mdu_busy(busy1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // hist[d][age]: the instruction that left ID 'age' cycles ago (v=0 for bubbles/no write)
  typedef struct { bit v; int a; bit ld; } ent_t;
  ent_t hist [2][1:NST];
  int   last_mdu [2];
  int   cyc;
  int   vectors, miscompares;
  bit   exp_st [2];
  int   exp_rs [2], exp_rt [2];
  bit   exp_busy [2];

  function automatic void src_exp(input int d, input bit used, input int addr,
                                  output bit haz, output int sel);
    int ready;
    haz = 1'b0;
    sel = 0;
    if (!used || addr == 0) return;
    for (int age = 1; age <= NST; age++) begin
      if (hist[d][age].v && hist[d][age].a == addr) begin
        if (age == NST) return;
        if (d == 0) haz = 1'b1;
        else begin
          ready = hist[d][age].ld ? LRDY : ARDY;
          if (age >= ready) sel = age;
          else haz = 1'b1;
        end
        return;
      end
    end
  endfunction

  task automatic model_eval();
    bit hrs, hrt, hmdu;
    int srs, srt, dt;
    for (int d = 0; d < 2; d++) begin
      src_exp(d, id_rs_used, int'(id_rs_addr), hrs, srs);
      src_exp(d, id_rt_used, int'(id_rt_addr), hrt, srt);
      dt = cyc - last_mdu[d];
      exp_busy[d] = (MLAT > 0) && (dt >= 1) && (dt <= MLAT);
      hmdu = (id_reads_hilo || id_is_mdu) && exp_busy[d];
      exp_st[d] = id_valid && !flush && (hrs || hrt || hmdu);
      exp_rs[d] = srs;
      exp_rt[d] = srt;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic eval();
    @(negedge clk);
    model_eval();
    check("stall_out[ilk]",  int'(st0),   int'(exp_st[0]));
    check("fwd_rs_sel[ilk]", int'(rs0),   exp_rs[0]);
    check("fwd_rt_sel[ilk]", int'(rt0),   exp_rt[0]);
    check("mdu_busy[ilk]",   int'(busy0), int'(exp_busy[0]));
    check("stall_out[fwd]",  int'(st1),   int'(exp_st[1]));
    check("fwd_rs_sel[fwd]", int'(rs1),   exp_rs[1]);
    check("fwd_rt_sel[fwd]", int'(rt1),   exp_rt[1]);
    check("mdu_busy[fwd]",   int'(busy1), int'(exp_busy[1]));
  endtask

  task automatic adv();
    bit acc;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        for (int k = 1; k <= NST; k++) hist[d][k] = '{1'b0, 0, 1'b0};
        last_mdu[d] = -1000;
      end else begin
        acc = id_valid && !exp_st[d] && !flush;
        for (int k = NST; k >= 2; k--) hist[d][k] = hist[d][k-1];
        hist[d][1] = '{acc && id_wr_en && (id_wr_addr != 0), int'(id_wr_addr), id_is_load};
        if (acc && id_is_mdu) last_mdu[d] = cyc;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic ins(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                     input bit wen, input int wa, input bit ld, input bit mdu,
                     input bit hilo, input bit fl);
    id_valid = v;   id_rs_addr = AW'(rs); id_rs_used = rsu;
    id_rt_addr = AW'(rt); id_rt_used = rtu;
    id_wr_en = wen; id_wr_addr = AW'(wa); id_is_load = ld;
    id_is_mdu = mdu; id_reads_hilo = hilo; flush = fl;
  endtask

  task automatic nops(input int n);
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin eval(); adv(); end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    for (int d = 0; d < 2; d++) begin
      for (int k = 1; k <= NST; k++) hist[d][k] = '{1'b0, 0, 1'b0};
      last_mdu[d] = -1000;
      exp_st[d] = 1'b0;
    end
    reset = 1'b1;
    ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    adv(); adv();
    // Reset state: a demanding instruction still sees a clean scoreboard
    ins(1, 3, 1, 4, 1, 1, 5, 0, 1, 1, 0);
    eval();
    check("reset stall", int'(st0), 0);
    check("reset busy", int'(busy1), 0);
    check("reset rs sel", int'(rs1), 0);
    adv();
    reset = 1'b0;
    nops(1);

    // addu $3; then addu $4,$3,$1 held in ID
    ins(1, 1, 1, 2, 1, 1, 3, 0, 0, 0, 0); eval(); adv();
    ins(1, 3, 1, 1, 1, 1, 4, 0, 0, 0, 0);
    eval(); check("t1 ilk stall c1", int'(st0), 1);
            check("t1 fwd rs sel1", int'(rs1), 1);
            check("t1 fwd no stall", int'(st1), 0); adv();
    eval(); check("t1 ilk stall c2", int'(st0), 1);
            check("t1 fwd rs sel2", int'(rs1), 2); adv();
    eval(); check("t1 ilk accept", int'(st0), 0);
            check("t1 ilk rs sel", int'(rs0), 0); adv();
    nops(3);

    // rt dependency forwards from stage 1
    ins(1, 1, 1, 2, 1, 1, 3, 0, 0, 0, 0); eval(); adv();
    ins(1, 1, 1, 3, 1, 1, 4, 0, 0, 0, 0);
    eval(); check("t2 fwd rt sel1", int'(rt1), 1); adv();
    nops(3);

    // lw $5 then user of $5
    ins(1, 1, 1, 0, 0, 1, 5, 1, 0, 0, 0); eval(); adv();
    ins(1, 5, 1, 2, 1, 1, 6, 0, 0, 0, 0);
    eval(); check("t3 load stall", int'(st1), 1); adv();
    eval(); check("t3 load fwd", int'(rs1), 2);
            check("t3 load go", int'(st1), 0); adv();
    nops(3);
    ins(1, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0); eval(); adv();
    ins(1, 0, 1, 0, 1, 1, 6, 0, 0, 0, 0);
    eval(); check("t3 $0 ilk", int'(st0), 0);
            check("t3 $0 fwd", int'(st1), 0); adv();
    nops(3);

    // mult then mfhi, then mult then mult
    for (int rep = 0; rep < 2; rep++) begin
      ins(1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0); eval(); adv();
      if (rep == 0) ins(1, 0, 0, 0, 0, 1, 6, 0, 0, 1, 0);
      else          ins(1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < MLAT; i++) begin
        eval(); check("t4 mdu stall", int'(st1), 1);
                check("t4 mdu busy", int'(busy0), 1); adv();
      end
      eval(); check("t4 mdu go", int'(st1), 0);
              check("t4 mdu idle", int'(busy1), 0); adv();
    end
    nops(MLAT + 1);

    // flush of a dependent instruction; producer still blocks the next one
    ins(1, 1, 1, 2, 1, 1, 7, 0, 0, 0, 0); eval(); adv();
    ins(1, 7, 1, 2, 1, 1, 8, 0, 0, 0, 1);
    eval(); check("t5 flush ilk", int'(st0), 0);
            check("t5 flush fwd", int'(st1), 0); adv();
    ins(1, 7, 1, 2, 1, 1, 8, 0, 0, 0, 0);
    eval(); check("t5 after ilk", int'(st0), 1);
            check("t5 after fwd", int'(rs1), 2); adv();
    nops(3);

    // reset during a stall with the MDU counter at 3
    ins(1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0); eval(); adv();
    ins(1, 1, 1, 2, 1, 1, 9, 0, 0, 0, 0); eval(); adv();
    ins(1, 9, 1, 2, 1, 1, 10, 0, 0, 1, 0);
    reset = 1'b1;
    eval(); check("t6 pre stall", int'(st0), 1);
            check("t6 pre busy", int'(busy0), 1); adv();
    reset = 1'b0;
    eval(); check("t6 post stall", int'(st0), 0);
            check("t6 post busy", int'(busy0), 0);
            check("t6 post sel", int'(rs1), 0); adv();
    nops(3);

    // Randomized traffic on a small register set to provoke many hazards
    for (int n = 0; n < 3000; n++) begin
      ins($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 1),
          $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 9) < 7,
          $urandom_range(0, 3), $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 199) == 0);
      eval(); adv();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
